// File: rtl/dprintf_2_mux.sv
// -----------------------------------------------------------------------------
// dprintf_2_mux
//
// Two-requester arbiter for the dprintf request bus, placed directly upstream of
// teletext_dprintf. Each requester port owns a one-entry holding register so a
// source is acknowledged promptly even while the downstream formatter is busy.
// The two holding registers are drained round-robin onto a single registered
// valid/ack output towards the formatter, one request at a time.
//
// Parameters
//   PRIORITY_RESET       port preferred first after reset (0 = A, 1 = B)
//
// Ports
//   clk                  clock, all state changes on the rising edge
//   reset_n              synchronous active-low reset
//   req_a__valid         port A request valid, fields held stable until ack_a
//   req_a__address       port A display address (16 bits)
//   req_a__data_0/_1     port A data words (64 bits each)
//   ack_a                port A acknowledge, one-cycle registered pulse
//   req_b__*, ack_b      port B, same semantics as port A
//   dprintf_req__valid   forwarded request valid (registered)
//   dprintf_req__address forwarded address (registered)
//   dprintf_req__data_0  forwarded data word 0 (registered)
//   dprintf_req__data_1  forwarded data word 1 (registered)
//   dprintf_ack          downstream acknowledge from teletext_dprintf
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module dprintf_2_mux #(
   parameter logic PRIORITY_RESET = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_a__valid,
   input  logic [15:0] req_a__address,
   input  logic [63:0] req_a__data_0,
   input  logic [63:0] req_a__data_1,
   output logic        ack_a,
   input  logic        req_b__valid,
   input  logic [15:0] req_b__address,
   input  logic [63:0] req_b__data_0,
   input  logic [63:0] req_b__data_1,
   output logic        ack_b,
   output logic        dprintf_req__valid,
   output logic [15:0] dprintf_req__address,
   output logic [63:0] dprintf_req__data_0,
   output logic [63:0] dprintf_req__data_1,
   input  logic        dprintf_ack
);

   // A request payload is packed as {address, data_0, data_1}.
   localparam int RW = 144;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic            full_a_q, full_a_d;
   logic            full_b_q, full_b_d;
   logic [RW-1:0]   hold_a_q, hold_a_d;
   logic [RW-1:0]   hold_b_q, hold_b_d;
   logic [RW-1:0]   out_q, out_d;
   logic            out_valid_q, out_valid_d;
   logic            ack_a_q, ack_a_d;
   logic            ack_b_q, ack_b_d;
   logic            prio_q, prio_d;   // 0 = A preferred, 1 = B preferred
   logic            srv_q, srv_d;     // port whose request sits in the output regs

   logic            cap_a, cap_b;
   logic            load_a, load_b;
   logic            winner;

   // Capture qualifiers. The !ack term blocks a second capture of a valid that
   // the requester is still holding during its ack cycle.
   assign cap_a = req_a__valid & ~ack_a_q & ~full_a_q;
   assign cap_b = req_b__valid & ~ack_b_q & ~full_b_q;

   // Winner selection: the only full port, or the priority port when both are full.
   always_comb begin
      winner = 1'b0;
      if (full_a_q && full_b_q) begin
         winner = prio_q;
      end else if (full_b_q) begin
         winner = 1'b1;
      end else begin
         winner = 1'b0;
      end
   end

   // Output FSM: load a holding register when idle, wait for the downstream ack when busy.
   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      prio_d      = prio_q;
      srv_d       = srv_q;
      load_a      = 1'b0;
      load_b      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // dprintf_ack is deliberately ignored here.
            if (full_a_q || full_b_q) begin
               out_valid_d = 1'b1;
               srv_d       = winner;
               state_d     = ST_BUSY;
               if (winner) begin
                  out_d  = hold_b_q;
                  load_b = 1'b1;
               end else begin
                  out_d  = hold_a_q;
                  load_a = 1'b1;
               end
            end else begin
               out_valid_d = 1'b0;
            end
         end
         ST_BUSY: begin
            if (dprintf_ack) begin
               // Valid drops for at least this one cycle, giving the gap
               // between consecutive forwarded requests.
               out_valid_d = 1'b0;
               prio_d      = ~srv_q;
               state_d     = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // Holding registers and ack pulses. Capture needs !full and load needs full,
   // so the two never hit the same port in one cycle.
   always_comb begin
      hold_a_d = hold_a_q;
      hold_b_d = hold_b_q;
      full_a_d = full_a_q;
      full_b_d = full_b_q;
      ack_a_d  = cap_a;
      ack_b_d  = cap_b;

      if (cap_a) begin
         hold_a_d = {req_a__address, req_a__data_0, req_a__data_1};
         full_a_d = 1'b1;
      end else if (load_a) begin
         full_a_d = 1'b0;
      end else begin
         full_a_d = full_a_q;
      end

      if (cap_b) begin
         hold_b_d = {req_b__address, req_b__data_0, req_b__data_1};
         full_b_d = 1'b1;
      end else if (load_b) begin
         full_b_d = 1'b0;
      end else begin
         full_b_d = full_b_q;
      end
   end

   // State register; reset discards pending and in-flight requests without acking them.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         full_a_q    <= 1'b0;
         full_b_q    <= 1'b0;
         hold_a_q    <= {RW{1'b0}};
         hold_b_q    <= {RW{1'b0}};
         out_q       <= {RW{1'b0}};
         out_valid_q <= 1'b0;
         ack_a_q     <= 1'b0;
         ack_b_q     <= 1'b0;
         prio_q      <= PRIORITY_RESET;
         srv_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         full_a_q    <= full_a_d;
         full_b_q    <= full_b_d;
         hold_a_q    <= hold_a_d;
         hold_b_q    <= hold_b_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         ack_a_q     <= ack_a_d;
         ack_b_q     <= ack_b_d;
         prio_q      <= prio_d;
         srv_q       <= srv_d;
      end
   end

   assign ack_a                = ack_a_q;
   assign ack_b                = ack_b_q;
   assign dprintf_req__valid   = out_valid_q;
   assign dprintf_req__address = out_q[143:128];
   assign dprintf_req__data_0  = out_q[127:64];
   assign dprintf_req__data_1  = out_q[63:0];

endmodule

// File: tb/tb_dprintf_2_mux.sv
// -----------------------------------------------------------------------------
// tb_dprintf_2_mux
//
// Table-driven cycle checks for the simple cases, plus per-port requester models,
// a downstream ack responder with programmable delay, and a scoreboard: each
// request is pushed to its port's expected queue when it is handed to a requester
// and popped when the DUT completes a forwarded transfer.
// Cycle k = the interval just after the k-th rising edge following reset release;
// inputs are driven and outputs sampled 1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_dprintf_2_mux;

   typedef struct packed {
      logic [15:0] addr;
      logic [63:0] d0;
      logic [63:0] d1;
   } req_t;

   typedef struct {
      logic        a_v;
      logic        b_v;
      logic        exp_ack_a;
      logic        exp_ack_b;
      logic        exp_valid;
      logic [15:0] exp_addr;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        src_valid [2];
   req_t        src_req [2];
   logic        dack;
   logic        ack_a, ack_b;
   logic        dprintf_req__valid;
   logic [15:0] dprintf_req__address;
   logic [63:0] dprintf_req__data_0;
   logic [63:0] dprintf_req__data_1;

   always #5 clk = ~clk;

   dprintf_2_mux #(.PRIORITY_RESET(1'b0)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .req_a__valid         (src_valid[0]),
      .req_a__address       (src_req[0].addr),
      .req_a__data_0        (src_req[0].d0),
      .req_a__data_1        (src_req[0].d1),
      .ack_a                (ack_a),
      .req_b__valid         (src_valid[1]),
      .req_b__address       (src_req[1].addr),
      .req_b__data_0        (src_req[1].d0),
      .req_b__data_1        (src_req[1].d1),
      .ack_b                (ack_b),
      .dprintf_req__valid   (dprintf_req__valid),
      .dprintf_req__address (dprintf_req__address),
      .dprintf_req__data_0  (dprintf_req__data_0),
      .dprintf_req__data_1  (dprintf_req__data_1),
      .dprintf_ack          (dack)
   );

   int   total = 0;
   int   bad   = 0;
   req_t pend [2][$];
   req_t exp_q [2][$];
   int   served [$];
   int   ack_cnt [2];
   int   xfer_cnt;
   logic linger [2];
   logic src_en;
   int   ack_delay;
   int   resp_cnt;
   logic rec_valid;
   logic rec_dack;
   req_t rec_req;

   task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chkn(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic req_t cur_out();
      req_t r;
      r.addr = dprintf_req__address;
      r.d0   = dprintf_req__data_0;
      r.d1   = dprintf_req__data_1;
      return r;
   endfunction

   function automatic req_t mkreq(input logic [15:0] a, input logic [63:0] d0, input logic [63:0] d1);
      req_t r;
      r.addr = a;
      r.d0   = d0;
      r.d1   = d1;
      return r;
   endfunction

   function automatic vec_t mkvec(input logic av, input logic bv, input logic aa, input logic ab,
                                  input logic v, input logic [15:0] ad);
      vec_t x;
      x.a_v = av; x.b_v = bv; x.exp_ack_a = aa; x.exp_ack_b = ab; x.exp_valid = v; x.exp_addr = ad;
      return x;
   endfunction

   // Hands a request to a requester model and records it as expected output.
   task automatic enqueue(input int p, input req_t r);
      pend[p].push_back(r);
      exp_q[p].push_back(r);
   endtask

   // Port of a forwarded request is encoded in the address high byte (0x0B = B).
   task automatic sb_pop(input req_t got);
      int   p;
      req_t e;
      p = (got.addr[15:8] == 8'h0B) ? 1 : 0;
      served.push_back(p);
      xfer_cnt++;
      total++;
      if (exp_q[p].size() == 0) begin
         bad++;
         $display("FAIL sb_unexpected port=%0d actual=%h required=none", p, got);
      end else begin
         e = exp_q[p].pop_front();
         if (got !== e) begin
            bad++;
            $display("FAIL sb_data port=%0d actual=%h required=%h", p, got, e);
         end
      end
   endtask

   task automatic src_step(input int p, input logic ackv);
      if (ackv && src_valid[p] && !linger[p]) begin
         if (pend[p].size() > 0) void'(pend[p].pop_front());
         if (pend[p].size() > 0) begin
            src_req[p] = pend[p][0];
         end else begin
            linger[p] = 1'b1;   // keep valid through the ack cycle, drop next cycle
         end
      end else if (linger[p]) begin
         src_valid[p] = 1'b0;
         linger[p]    = 1'b0;
      end else if (!src_valid[p] && pend[p].size() > 0) begin
         src_req[p]   = pend[p][0];
         src_valid[p] = 1'b1;
      end
   endtask

   // One cycle: monitor the previous cycle, then run responder and requesters.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rec_valid && rec_dack) begin
         sb_pop(rec_req);
         chk("valid_gap", 144'(dprintf_req__valid), 144'(1'b0));
      end else if (rec_valid) begin
         chk("hold_valid", 144'(dprintf_req__valid), 144'(1'b1));
         chk("hold_fields", 144'(cur_out()), 144'(rec_req));
      end
      if (ack_a) ack_cnt[0]++;
      if (ack_b) ack_cnt[1]++;
      if (dprintf_req__valid) begin
         dack = (resp_cnt == ack_delay);
         resp_cnt++;
      end else begin
         dack     = 1'b0;
         resp_cnt = 0;
      end
      if (src_en) begin
         src_step(0, ack_a);
         src_step(1, ack_b);
      end
      rec_valid = dprintf_req__valid;
      rec_dack  = dack;
      rec_req   = cur_out();
   endtask

   task automatic clear_bench();
      for (int p = 0; p < 2; p++) begin
         pend[p].delete();
         exp_q[p].delete();
         ack_cnt[p]   = 0;
         linger[p]    = 1'b0;
         src_valid[p] = 1'b0;
         src_req[p]   = '0;
      end
      served.delete();
      xfer_cnt  = 0;
      src_en    = 1'b0;
      dack      = 1'b0;
      resp_cnt  = 0;
      rec_valid = 1'b0;
      rec_dack  = 1'b0;
      rec_req   = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_bench();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   function automatic logic drained();
      return pend[0].size() == 0 && pend[1].size() == 0 && !src_valid[0] && !src_valid[1] &&
             exp_q[0].size() == 0 && exp_q[1].size() == 0 && !dprintf_req__valid && !rec_valid;
   endfunction

   task automatic run_drain(input string nm, input int budget);
      for (int c = 0; c < budget && !drained(); c++) tick();
      chkn({nm, "_drained"}, int'(drained()), 1);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ack_a"}, 144'(ack_a), 144'(1'b0));
      chk({nm, "_ack_b"}, 144'(ack_b), 144'(1'b0));
      chk({nm, "_valid"}, 144'(dprintf_req__valid), 144'(1'b0));
      chk({nm, "_fields"}, 144'(cur_out()), 144'(0));
   endtask

   vec_t t1 [8];
   vec_t t2 [12];
   int   a0, b0;

   initial begin
      // Cycle tables: a_v, b_v, ack_a, ack_b, valid, address.
      t1[0] = mkvec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      t1[1] = mkvec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      for (int k = 2; k < 6; k++) t1[k] = mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0123);
      t1[6] = mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      t1[7] = mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

      t2[0] = mkvec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      t2[1] = mkvec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      for (int k = 2; k < 6; k++) t2[k] = mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0A01);
      t2[6] = mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int k = 7; k < 11; k++) t2[k] = mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0B01);
      t2[11] = mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

      // Reset state.
      do_reset();
      chk_all_zero("reset");

      // 1: single request on A, downstream ack 3 cycles after valid.
      ack_delay = 3;
      src_req[0] = mkreq(16'h0123, 64'h4142434400000000, 64'h0);
      exp_q[0].push_back(src_req[0]);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         chk($sformatf("t1_ack_a_c%0d", k), 144'(ack_a), 144'(t1[k].exp_ack_a));
         chk($sformatf("t1_ack_b_c%0d", k), 144'(ack_b), 144'(t1[k].exp_ack_b));
         chk($sformatf("t1_valid_c%0d", k), 144'(dprintf_req__valid), 144'(t1[k].exp_valid));
         if (t1[k].exp_valid) begin
            chk($sformatf("t1_fields_c%0d", k), 144'(cur_out()), 144'(src_req[0]));
         end
         src_valid[0] = t1[k].a_v;
         src_valid[1] = t1[k].b_v;
      end
      chkn("t1_xfers", xfer_cnt, 1);

      // 2: A and B together after reset; A first, B after an idle gap.
      do_reset();
      ack_delay = 3;
      src_req[0] = mkreq(16'h0A01, 64'h1111111111111111, 64'h2222222222222222);
      src_req[1] = mkreq(16'h0B01, 64'h3333333333333333, 64'h4444444444444444);
      exp_q[0].push_back(src_req[0]);
      exp_q[1].push_back(src_req[1]);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) tick();
         chk($sformatf("t2_ack_a_c%0d", k), 144'(ack_a), 144'(t2[k].exp_ack_a));
         chk($sformatf("t2_ack_b_c%0d", k), 144'(ack_b), 144'(t2[k].exp_ack_b));
         chk($sformatf("t2_valid_c%0d", k), 144'(dprintf_req__valid), 144'(t2[k].exp_valid));
         if (t2[k].exp_valid) begin
            chk($sformatf("t2_addr_c%0d", k), 144'(dprintf_req__address), 144'(t2[k].exp_addr));
         end
         src_valid[0] = t2[k].a_v;
         src_valid[1] = t2[k].b_v;
      end
      chkn("t2_xfers", xfer_cnt, 2);

      // 3: both ports streaming; forwarded order alternates A,B,A,B.
      do_reset();
      ack_delay = 1;
      for (int i = 0; i < 4; i++) begin
         enqueue(0, mkreq(16'h0A10 + 16'(i), 64'hA000 + 64'(i), 64'h5A5A5A5A00000000 + 64'(i)));
         enqueue(1, mkreq(16'h0B10 + 16'(i), 64'hB000 + 64'(i), 64'hA5A5A5A500000000 + 64'(i)));
      end
      src_en = 1'b1;
      run_drain("t3", 200);
      chkn("t3_count", served.size(), 8);
      for (int i = 0; i < served.size() && i < 8; i++) chkn($sformatf("t3_order_%0d", i), served[i], i % 2);

      // 4: downstream ack withheld 20 cycles while both ports keep requesting.
      do_reset();
      ack_delay = 20;
      for (int i = 0; i < 3; i++) begin
         enqueue(0, mkreq(16'h0A20 + 16'(i), $urandom(), $urandom()));
         enqueue(1, mkreq(16'h0B20 + 16'(i), $urandom(), $urandom()));
      end
      src_en = 1'b1;
      for (int c = 0; c < 10 && !dprintf_req__valid; c++) tick();
      chk("t4_first_valid", 144'(dprintf_req__valid), 144'(1'b1));
      a0 = ack_cnt[0];
      b0 = ack_cnt[1];
      for (int c = 0; c < 40 && !dack; c++) tick();
      chk("t4_stall_end", 144'(dack), 144'(1'b1));
      chkn("t4_stall_acks_a", ack_cnt[0] - a0, 1);
      chkn("t4_stall_acks_b", ack_cnt[1] - b0, 0);
      run_drain("t4", 400);
      chkn("t4_acks_a", ack_cnt[0], 3);
      chkn("t4_acks_b", ack_cnt[1], 3);
      chkn("t4_xfers", xfer_cnt, 6);

      // 5: reset for one cycle while BUSY with both holding registers full.
      do_reset();
      ack_delay = 20;
      for (int i = 0; i < 2; i++) begin
         enqueue(0, mkreq(16'h0A30 + 16'(i), 64'h77, 64'h88));
         enqueue(1, mkreq(16'h0B30 + 16'(i), 64'h99, 64'hAA));
      end
      src_en = 1'b1;
      for (int c = 0; c < 6; c++) tick();
      chk("t5_busy_before", 144'(dprintf_req__valid), 144'(1'b1));
      reset_n = 1'b0;
      clear_bench();
      @(posedge clk);
      #1;
      chk_all_zero("t5_after_reset");
      reset_n = 1'b1;
      ack_delay = 2;
      enqueue(0, mkreq(16'h0A40, 64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF));
      src_en = 1'b1;
      run_drain("t5", 50);
      chkn("t5_xfers", xfer_cnt, 1);
      chkn("t5_acks_a", ack_cnt[0], 1);
      chkn("t5_acks_b", ack_cnt[1], 0);

      // 6: requester holds valid through its ack cycle, drops it the cycle after.
      do_reset();
      ack_delay = 0;
      enqueue(0, mkreq(16'h0A50, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0));
      src_en = 1'b1;
      run_drain("t6", 50);
      for (int c = 0; c < 5; c++) tick();
      chkn("t6_acks_a", ack_cnt[0], 1);
      chkn("t6_xfers", xfer_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
